key_strobe_gen: RTL and testbench

Converts a raw, bouncing push-button input into a clean, registered, single-cycle enable strobe, one strobe per press. It is the producer side of the counter's enable interface: its enable output drives the enable input of the 8-bit upcounter. The block also exports the debounced key level for status display.

---
 rtl/key_strobe_gen.sv | 88 ++++++++
 tb/tb_key_strobe_gen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/key_strobe_gen.sv
// key_strobe_gen: debounces a bouncing push-button into a one-cycle enable strobe per press plus a debounced level.
// Optional auto-repeat while held is built when KEY_STROBE_AUTOREPEAT_EN is defined.
module key_strobe_gen #(
    parameter int DEBOUNCE_CYC      = 500000,
    parameter int KEY_ACTIVE_LOW    = 1,
    parameter int REPEAT_DELAY_CYC  = 25000000,
    parameter int REPEAT_PERIOD_CYC = 5000000
) (
    input  logic clk50m,
    input  logic rst,
    input  logic key_in,
    output logic enable,
    output logic key_lvl
);
    localparam int MAX_AB = (DEBOUNCE_CYC > REPEAT_DELAY_CYC) ? DEBOUNCE_CYC : REPEAT_DELAY_CYC;
    localparam int MAXC = (MAX_AB > REPEAT_PERIOD_CYC) ? MAX_AB : REPEAT_PERIOD_CYC;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic INACT = (KEY_ACTIVE_LOW != 0);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
`ifdef KEY_STROBE_AUTOREPEAT_EN
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY_CYC - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD_CYC - 1);
    logic rpt;
`endif
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;
    state_t state;
    logic [1:0] sync;
    logic [CW-1:0] cnt, cnt_inc;
    logic key_s;
    assign key_s = sync[1] ^ INACT;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            sync    <= {2{INACT}};
            state   <= IDLE;
            cnt     <= '0;
            enable  <= 1'b0;
            key_lvl <= 1'b0;
`ifdef KEY_STROBE_AUTOREPEAT_EN
            rpt     <= 1'b0;
`endif
        end else begin
            sync   <= {sync[0], key_in};
            enable <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (key_s) state <= PRESS_DB;
                end
                PRESS_DB:
                    if (!key_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state   <= HELD;
                        cnt     <= '0;
                        enable  <= 1'b1;
                        key_lvl <= 1'b1;
                    end else cnt <= cnt_inc;
                HELD:
                    if (!key_s) begin
                        state <= RELEASE_DB;
                        cnt   <= '0;
`ifdef KEY_STROBE_AUTOREPEAT_EN
                        rpt   <= 1'b0;
                    end else if (cnt == (rpt ? PER_LAST : DLY_LAST)) begin
                        // first repeat waits the long delay, later ones the short period
                        enable <= 1'b1;
                        cnt    <= '0;
                        rpt    <= 1'b1;
                    end else cnt <= cnt_inc;
`else
                    end
`endif
                RELEASE_DB:
                    if (key_s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        key_lvl <= 1'b0;
                    end else cnt <= cnt_inc;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_strobe_gen.sv
// tb_key_strobe_gen: directed, table-driven bench for key_strobe_gen (DEBOUNCE_CYC=8, repeat 20/6, active-low key).
module tb_key_strobe_gen;
    localparam int DB = 8, RD = 20, RP = 6;
    logic clk50m = 1'b0, rst = 1'b1, key_in = 1'b1;
    logic enable, key_lvl, prev_en = 1'b0;
    logic [7:0] upc = 8'd0, u0;
    int cyc = 0, en_cnt = 0, dbl = 0, pass_n = 0, tot_n = 0;
    int c0, n0, t0, lat;
    int en_t[$];
    typedef struct {int low; int gap; int en; logic lvl;} vec_t;
    vec_t vt[6];
    int offs[6];

    key_strobe_gen #(.DEBOUNCE_CYC(DB), .KEY_ACTIVE_LOW(1), .REPEAT_DELAY_CYC(RD), .REPEAT_PERIOD_CYC(RP)) dut (
        .clk50m(clk50m), .rst(rst), .key_in(key_in), .enable(enable), .key_lvl(key_lvl)
    );

    always #5 clk50m = ~clk50m;
    always @(posedge clk50m) cyc <= cyc + 1;
    always @(posedge clk50m) if (enable) upc <= upc + 8'd1;
    always @(negedge clk50m) begin
        if (enable) begin
            en_cnt++;
            en_t.push_back(cyc);
        end
        if (enable && prev_en) dbl++;
        prev_en = enable;
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        tot_n++;
        if (act == exp_v) pass_n++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk50m);
        #1;
    endtask

    initial begin
        vt = '{'{5, 20, 0, 1'b0}, '{7, 20, 0, 1'b0}, '{1, 20, 0, 1'b0},
               '{9, 20, 1, 1'b0}, '{12, 20, 1, 1'b1}, '{20, 20, 1, 1'b1}};
        offs = '{0, 20, 26, 32, 38, 44};
        for (int i = 0; i < 5; i++) begin
            key_in = i[0];
            wait_n(1);
            chk("rst_enable", int'(enable), 0);
            chk("rst_key_lvl", int'(key_lvl), 0);
        end
        key_in = 1'b1;
        rst = 1'b0;
        wait_n(15);
        chk("rst_release_no_strobe", en_cnt, 0);
        chk("rst_release_lvl", int'(key_lvl), 0);

        n0 = en_t.size();
        t0 = cyc;
        key_in = 1'b0;
        wait_n(15);
        chk("clean_strobes", en_t.size() - n0, 1);
        lat = (en_t.size() > n0) ? en_t[n0] - t0 : -1;
        chk("clean_latency_in_10_12", int'(lat >= 10 && lat <= 12), 1);
        chk("clean_lvl_high", int'(key_lvl), 1);
        key_in = 1'b1;
        wait_n(20);
        chk("clean_lvl_low", int'(key_lvl), 0);

        c0 = en_cnt;
        u0 = upc;
        for (int i = 0; i < 3; i++) begin
            key_in = 1'b0;
            wait_n(3);
            key_in = 1'b1;
            wait_n(2);
        end
        chk("bouncy_no_early_strobe", en_cnt - c0, 0);
        n0 = en_t.size();
        t0 = cyc;
        key_in = 1'b0;
        wait_n(15);
        chk("bouncy_strobes", en_cnt - c0, 1);
        lat = (en_t.size() > n0) ? en_t[n0] - t0 : -1;
        chk("bouncy_latency_in_10_12", int'(lat >= 10 && lat <= 12), 1);
        key_in = 1'b1;
        wait_n(20);
        chk("bouncy_upcounter", int'(8'(upc - u0)), 1);

        for (int i = 0; i < 6; i++) begin
            c0 = en_cnt;
            key_in = 1'b0;
            wait_n(vt[i].low);
            chk($sformatf("vec%0d_lvl_held", i), int'(key_lvl), int'(vt[i].lvl));
            key_in = 1'b1;
            wait_n(vt[i].gap);
            chk($sformatf("vec%0d_strobes", i), en_cnt - c0, vt[i].en);
            chk($sformatf("vec%0d_lvl_released", i), int'(key_lvl), 0);
        end

        c0 = en_cnt;
        key_in = 1'b0;
        wait_n(15);
        for (int i = 0; i < 2; i++) begin
            key_in = 1'b1;
            wait_n(2);
            key_in = 1'b0;
            wait_n(2);
        end
        key_in = 1'b1;
        wait_n(8);
        chk("relbounce_lvl_still_high", int'(key_lvl), 1);
        wait_n(6);
        chk("relbounce_lvl_fell", int'(key_lvl), 0);
        wait_n(10);
        chk("relbounce_strobes", en_cnt - c0, 1);

        u0 = upc;
        repeat (10) begin
            key_in = 1'b0;
            wait_n(12);
            key_in = 1'b1;
            wait_n(20);
        end
        chk("ten_presses_upcounter", int'(8'(upc - u0)), 10);

        key_in = 1'b0;
        wait_n(6);
        chk("midpress_lvl_low", int'(key_lvl), 0);
        rst = 1'b1;
        wait_n(3);
        chk("midpress_rst_enable", int'(enable), 0);
        chk("midpress_rst_lvl", int'(key_lvl), 0);
        c0 = en_cnt;
        n0 = en_t.size();
        t0 = cyc;
        rst = 1'b0;
        wait_n(56);
        key_in = 1'b1;
        wait_n(20);
        lat = (en_t.size() > n0) ? en_t[n0] - t0 : -1;
        chk("midpress_latency_in_10_12", int'(lat >= 10 && lat <= 12), 1);
`ifdef KEY_STROBE_AUTOREPEAT_EN
        chk("midpress_repeat_strobes", en_cnt - c0, 6);
        if (en_t.size() >= n0 + 6)
            for (int k = 1; k < 6; k++)
                chk($sformatf("repeat_offset%0d", k), en_t[n0 + k] - en_t[n0], offs[k]);
`else
        chk("midpress_strobes", en_cnt - c0, 1);
`endif
        chk("midpress_lvl_released", int'(key_lvl), 0);
        chk("no_back_to_back_enable", dbl, 0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
